// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache between fetch and main memory.
// Hits answer combinationally. A miss stalls fetch while one line is refilled.
module icache_responder #(
  parameter int ARCH_LEN  = 32,
  parameter int LINE_BITS = 128,
  parameter int NUM_LINES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_in,
  input  logic [ARCH_LEN-1:0]  req_addr_in,
  input  logic                 kill_in,
  output logic                 rsp_valid_out,
  output logic [ARCH_LEN-1:0]  rsp_inst_out,
  output logic                 stall_fet_out,
  output logic                 mem_req_valid_out,
  output logic [ARCH_LEN-1:0]  mem_req_addr_out,
  input  logic                 mem_req_ready_in,
  input  logic                 mem_rsp_valid_in,
  input  logic [LINE_BITS-1:0] mem_rsp_data_in,
  output logic [1:0]           dbg_state_out
);

  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int WORDS  = LINE_BITS / ARCH_LEN;
  localparam int WORD_W = $clog2(WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ARCH_LEN - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Memory handshake: a request transfers in a cycle where mem_req_valid_out
  // and mem_req_ready_in are both high; until then valid and address hold.
  // The refill response is a single-cycle mem_rsp_valid_in pulse, no ready.
  state_e                state_q;
  logic                  mem_req_valid_q;
  logic [ARCH_LEN-1:0]   line_addr_q;
  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0]  data_q [NUM_LINES];

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [WORD_W-1:0]     req_word;
  logic [IDX_W-1:0]      fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic [LINE_BITS-1:0]  sel_line;
  logic [ARCH_LEN-1:0]   sel_inst;
  logic                  hit;
  logic                  miss;
  logic                  unused_addr_bits;

  assign req_idx          = req_addr_in[OFF_W +: IDX_W];
  assign req_tag          = req_addr_in[ARCH_LEN-1 -: TAG_W];
  assign req_word         = req_addr_in[OFF_W-1 -: WORD_W];
  assign fill_idx         = line_addr_q[OFF_W +: IDX_W];
  assign fill_tag         = line_addr_q[ARCH_LEN-1 -: TAG_W];
  assign unused_addr_bits = ^req_addr_in[OFF_W-WORD_W-1:0];

  assign hit  = req_valid_in & valid_q[req_idx] & (tag_q[req_idx] == req_tag) &
                (state_q == IDLE);
  assign miss = req_valid_in & ~hit & ~kill_in;

  always_comb begin
    sel_line = data_q[req_idx];
    sel_inst = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (req_word == WORD_W'(w)) sel_inst = sel_line[w*ARCH_LEN +: ARCH_LEN];
    end
  end

  assign rsp_valid_out     = hit;
  assign rsp_inst_out      = hit ? sel_inst : '0;
  // Gated by reset so the stall drops the moment reset asserts.
  assign stall_fet_out     = rst & (miss | (state_q != IDLE));
  assign mem_req_valid_out = mem_req_valid_q;
  assign mem_req_addr_out  = line_addr_q;
  assign dbg_state_out     = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      mem_req_valid_q <= 1'b0;
      line_addr_q     <= '0;
      valid_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            line_addr_q     <= {req_addr_in[ARCH_LEN-1:OFF_W], {OFF_W{1'b0}}};
            mem_req_valid_q <= 1'b1;
            state_q         <= REQ;
          end
        end
        REQ: begin
          // Acceptance wins over a same-cycle kill: the memory already owns it.
          if (mem_req_ready_in) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT;
          end else if (kill_in) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= IDLE;
          end
        end
        WAIT: begin
          if (mem_rsp_valid_in) begin
            valid_q[fill_idx] <= 1'b1;
            state_q           <= IDLE;
          end
        end
        default: begin
          mem_req_valid_q <= 1'b0;
          state_q         <= IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (state_q == WAIT && mem_rsp_valid_in) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_rsp_data_in;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed table-driven bench for icache_responder: one vector per clock cycle,
// plus a hand-written asynchronous-reset-during-refill sequence.
module tb_icache_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid_in;
  logic [31:0]  req_addr_in;
  logic         kill_in;
  logic         rsp_valid_out;
  logic [31:0]  rsp_inst_out;
  logic         stall_fet_out;
  logic         mem_req_valid_out;
  logic [31:0]  mem_req_addr_out;
  logic         mem_req_ready_in;
  logic         mem_rsp_valid_in;
  logic [127:0] mem_rsp_data_in;
  logic [1:0]   dbg_state_out;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  icache_responder #(.ARCH_LEN(32), .LINE_BITS(128), .NUM_LINES(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_in      (req_valid_in),
    .req_addr_in       (req_addr_in),
    .kill_in           (kill_in),
    .rsp_valid_out     (rsp_valid_out),
    .rsp_inst_out      (rsp_inst_out),
    .stall_fet_out     (stall_fet_out),
    .mem_req_valid_out (mem_req_valid_out),
    .mem_req_addr_out  (mem_req_addr_out),
    .mem_req_ready_in  (mem_req_ready_in),
    .mem_rsp_valid_in  (mem_rsp_valid_in),
    .mem_rsp_data_in   (mem_rsp_data_in),
    .dbg_state_out     (dbg_state_out)
  );

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic        kill;
    logic        rdy;
    logic        rspv;
    logic [31:0] fill;
    logic        e_rv;
    logic [31:0] e_inst;
    logic        e_stall;
    logic        e_mrv;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs[$];

  // Memory image: line 0x10 holds the given program, others a fixed pattern.
  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] r;
    if (a == 32'h10) begin
      r = {32'h0000_0493, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
    end else begin
      for (int k = 0; k < 4; k++) r[k*32 +: 32] = 32'hC000_0000 + a + 32'(k);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic rv, input logic [31:0] addr,
                              input logic kill, input logic rdy, input logic rspv,
                              input logic [31:0] fill, input logic e_rv,
                              input logic [31:0] e_inst, input logic e_stall,
                              input logic e_mrv, input logic [31:0] e_maddr);
    vec_t v;
    v.rv = rv; v.addr = addr; v.kill = kill; v.rdy = rdy; v.rspv = rspv;
    v.fill = fill; v.e_rv = e_rv; v.e_inst = e_inst; v.e_stall = e_stall;
    v.e_mrv = e_mrv; v.e_maddr = e_maddr;
    return v;
  endfunction

  task automatic check_outs(input string name, input logic e_rv,
                            input logic [31:0] e_inst, input logic e_stall,
                            input logic e_mrv, input logic [31:0] e_maddr);
    n_vec++;
    if (rsp_valid_out !== e_rv || rsp_inst_out !== e_inst ||
        stall_fet_out !== e_stall || mem_req_valid_out !== e_mrv ||
        mem_req_addr_out !== e_maddr) begin
      n_fail++;
      $display("FAIL %s: got rv=%b inst=%h stall=%b mrv=%b maddr=%h, want rv=%b inst=%h stall=%b mrv=%b maddr=%h",
               name, rsp_valid_out, rsp_inst_out, stall_fet_out, mem_req_valid_out,
               mem_req_addr_out, e_rv, e_inst, e_stall, e_mrv, e_maddr);
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] exp);
    n_vec++;
    if (dbg_state_out !== exp) begin
      n_fail++;
      $display("FAIL %s: got state=%0d, want state=%0d", name, dbg_state_out, exp);
    end
  endtask

  initial begin
    // Cold miss on 0x10, ready at once, latency 2, then hit stream.
    vecs.push_back(mk(1, 32'h10, 0, 1, 0, 0,     0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 32'h10, 0, 1, 0, 0,     0, 0, 1, 1, 32'h10));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0,     0, 0, 1, 0, 32'h10));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0,     0, 0, 1, 0, 32'h10));
    vecs.push_back(mk(1, 32'h10, 0, 0, 1, 32'h10, 0, 0, 1, 0, 32'h10));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0,     1, 32'h0030_0193, 0, 0, 32'h10));
    vecs.push_back(mk(1, 32'h14, 0, 0, 0, 0,     1, 32'h0020_0113, 0, 0, 32'h10));
    vecs.push_back(mk(1, 32'h18, 0, 0, 0, 0,     1, 32'h0010_0093, 0, 0, 32'h10));
    vecs.push_back(mk(1, 32'h1C, 0, 0, 0, 0,     1, 32'h0000_0493, 0, 0, 32'h10));
    // Conflict eviction 0x50, then 0x10 misses again (ready delayed a cycle).
    vecs.push_back(mk(1, 32'h50, 0, 0, 0, 0,     0, 0, 1, 0, 32'h10));
    vecs.push_back(mk(1, 32'h50, 0, 1, 0, 0,     0, 0, 1, 1, 32'h50));
    vecs.push_back(mk(1, 32'h50, 0, 0, 0, 0,     0, 0, 1, 0, 32'h50));
    vecs.push_back(mk(1, 32'h50, 0, 0, 1, 32'h50, 0, 0, 1, 0, 32'h50));
    vecs.push_back(mk(1, 32'h50, 0, 0, 0, 0,     1, 32'hC000_0050, 0, 0, 32'h50));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0,     0, 0, 1, 0, 32'h50));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0,     0, 0, 1, 1, 32'h10));
    vecs.push_back(mk(1, 32'h10, 0, 1, 0, 0,     0, 0, 1, 1, 32'h10));
    vecs.push_back(mk(1, 32'h10, 0, 0, 1, 32'h10, 0, 0, 1, 0, 32'h10));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0,     1, 32'h0030_0193, 0, 0, 32'h10));
    // Kill in REQ while ready is low: request dropped, 0x100 misses later.
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0,    0, 0, 1, 0, 32'h10));
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0,    0, 0, 1, 1, 32'h100));
    vecs.push_back(mk(1, 32'h100, 1, 0, 0, 0,    0, 0, 1, 1, 32'h100));
    vecs.push_back(mk(0, 32'h100, 0, 0, 0, 0,    0, 0, 0, 0, 32'h100));
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0,    0, 0, 1, 0, 32'h100));
    vecs.push_back(mk(1, 32'h100, 0, 1, 0, 0,    0, 0, 1, 1, 32'h100));
    vecs.push_back(mk(1, 32'h100, 0, 0, 1, 32'h100, 0, 0, 1, 0, 32'h100));
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0,    1, 32'hC000_0100, 0, 0, 32'h100));
    // Kill together with ready: accepted, refill completes.
    vecs.push_back(mk(1, 32'h300, 0, 0, 0, 0,    0, 0, 1, 0, 32'h100));
    vecs.push_back(mk(1, 32'h300, 1, 1, 0, 0,    0, 0, 1, 1, 32'h300));
    vecs.push_back(mk(0, 32'h300, 0, 0, 0, 0,    0, 0, 1, 0, 32'h300));
    vecs.push_back(mk(0, 32'h300, 0, 0, 1, 32'h300, 0, 0, 1, 0, 32'h300));
    vecs.push_back(mk(1, 32'h304, 0, 0, 0, 0,    1, 32'hC000_0301, 0, 0, 32'h300));
    // Kill in WAIT: line 0x200 still installed, 0x204 hits.
    vecs.push_back(mk(1, 32'h200, 0, 0, 0, 0,    0, 0, 1, 0, 32'h300));
    vecs.push_back(mk(1, 32'h200, 0, 1, 0, 0,    0, 0, 1, 1, 32'h200));
    vecs.push_back(mk(1, 32'h200, 1, 0, 0, 0,    0, 0, 1, 0, 32'h200));
    vecs.push_back(mk(0, 32'h200, 0, 0, 0, 0,    0, 0, 1, 0, 32'h200));
    vecs.push_back(mk(0, 32'h200, 0, 0, 1, 32'h200, 0, 0, 1, 0, 32'h200));
    vecs.push_back(mk(1, 32'h204, 0, 0, 0, 0,    1, 32'hC000_0201, 0, 0, 32'h200));
    // Lead-in to the reset-mid-WAIT sequence.
    vecs.push_back(mk(1, 32'h400, 0, 0, 0, 0,    0, 0, 1, 0, 32'h200));
    vecs.push_back(mk(1, 32'h400, 0, 1, 0, 0,    0, 0, 1, 1, 32'h400));
    vecs.push_back(mk(1, 32'h400, 0, 0, 0, 0,    0, 0, 1, 0, 32'h400));

    // Clock/reset.
    rst = 1'b0;
    req_valid_in = 1'b0; req_addr_in = '0; kill_in = 1'b0;
    mem_req_ready_in = 1'b0; mem_rsp_valid_in = 1'b0; mem_rsp_data_in = '0;
    repeat (3) @(negedge clk);
    #2;
    check_outs("reset_outputs", 0, 0, 0, 0, 32'h0);
    check_state("reset_state", 2'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      req_valid_in     = vecs[i].rv;
      req_addr_in      = vecs[i].addr;
      kill_in          = vecs[i].kill;
      mem_req_ready_in = vecs[i].rdy;
      mem_rsp_valid_in = vecs[i].rspv;
      mem_rsp_data_in  = line_of(vecs[i].fill);
      #2;
      check_outs($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_inst,
                 vecs[i].e_stall, vecs[i].e_mrv, vecs[i].e_maddr);
    end
    check_state("wait_before_reset", 2'd2);

    // Asynchronous reset while the 0x400 refill is outstanding.
    @(negedge clk);
    mem_req_ready_in = 1'b0;
    rst = 1'b0;
    #1;
    check_outs("async_reset_outputs", 0, 0, 0, 0, 32'h0);
    check_state("async_reset_state", 2'd0);
    @(negedge clk);
    rst = 1'b1;
    req_valid_in = 1'b0;
    @(negedge clk);
    mem_rsp_valid_in = 1'b1;
    mem_rsp_data_in  = line_of(32'h400);
    #2;
    check_outs("stray_rsp_ignored", 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    mem_rsp_valid_in = 1'b0;
    #2;
    check_state("idle_after_stray", 2'd0);
    req_valid_in = 1'b1;
    req_addr_in  = 32'h400;
    #1;
    check_outs("post_reset_400_miss", 0, 0, 1, 0, 32'h0);
    req_addr_in  = 32'h0;
    #1;
    check_outs("post_reset_0_miss", 0, 0, 1, 0, 32'h0);

    @(negedge clk);
    req_valid_in = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped, read-only instruction cache. It answers fetch-stage instruction requests and refills missing lines from main memory over the instruction bus, acting as initiator toward memory.
- It sits between fetch_stage and main_memory and is the source of the fetch-side stall (icache miss) that feeds stall_fet.
- Hits return the instruction combinationally in the request cycle.
- Misses hold the fetch stage until the line is installed.

Parameters:
- ARCH_LEN, 32, address and instruction width.
- LINE_BITS, 128, cache line width (4 instructions).
- NUM_LINES, 4, number of lines; must be a power of 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req_valid_in  input  1  fetch presents a valid PC this cycle.
- req_addr_in  input  ARCH_LEN  fetch PC; bits [1:0] ignored.
- kill_in  input  1  branch taken in EXE; the current fetch request is obsolete.
- rsp_valid_out  output  1  rsp_inst_out is valid for req_addr_in this cycle.
- rsp_inst_out  output  ARCH_LEN  instruction word.
- stall_fet_out  output  1  miss in progress; fetch must hold its PC.
- mem_req_valid_out  output  1  line refill request to memory.
- mem_req_addr_out  output  ARCH_LEN  line-aligned refill address (bits [3:0] = 0).
- mem_req_ready_in  input  1  memory accepts the request this cycle.
- mem_rsp_valid_in  input  1  refill line data valid, single-cycle pulse.
- mem_rsp_data_in  input  LINE_BITS  line data; word k occupies bits [32k+31:32k].

Behaviour:
- Address split with defaults: offset [3:0], word select [3:2], index [5:4], tag [31:6]. Widths derive from the parameters.
- Storage per line: valid bit, tag, data. Reset clears all valid bits; tag and data are not reset.
- Reset values: rsp_valid_out=0, rsp_inst_out=0, stall_fet_out=0, mem_req_valid_out=0, mem_req_addr_out=0. FSM resets to IDLE.
- Hit condition: req_valid_in & valid[idx] & tag[idx]==tag(req_addr_in) & state==IDLE.
- On a hit (combinational): rsp_valid_out=1, rsp_inst_out=selected word, stall_fet_out=0.
- When rsp_valid_out=0, rsp_inst_out=0.
- stall_fet_out = req_valid_in & ~hit & ~kill_in, or state != IDLE.

FSM states:
- IDLE:
  - On miss (req_valid_in & ~hit & ~kill_in): latch the line address (req_addr_in with [3:0] cleared); go to REQ.
  - mem_rsp_valid_in in IDLE is ignored.
- REQ:
  - mem_req_valid_out=1 and mem_req_addr_out=latched address, both registered and stable until accepted.
  - On mem_req_ready_in: go to WAIT.
  - On kill_in without mem_req_ready_in in the same cycle: drop the request and go to IDLE next cycle.
  - kill_in together with mem_req_ready_in: the request counts as accepted; go to WAIT.
- WAIT:
  - mem_req_valid_out=0.
  - On mem_req_valid_in... precisely, on mem_rsp_valid_in: write data, tag and valid for the latched index; go to IDLE.
  - kill_in in WAIT does not abort: the refill completes and the line is installed. The kill is only recorded as not producing a response.

After refill:
- The first IDLE cycle re-evaluates the held req_addr_in and hits.
- Miss-to-response latency = 1 (IDLE→REQ) + request wait + memory latency + 1 cycle (install).
- With ready=1 immediately and memory latency L: response arrives L+3 cycles after the miss cycle.

Other rules:
- Same-index replacement: the refill overwrites the line unconditionally (no associativity).
- Only one outstanding refill; there is no miss-under-miss.
- Asynchronous reset mid-refill: return to IDLE immediately and clear valid bits. A later mem_rsp_valid_in is ignored.
- req_addr_in may change only when stall_fet_out=0 or kill_in=1. The latched address is used for the install, not the live input.

Test Plan:
- Reset, then req 0x0000_0010 with mem ready=1 and latency 2, returning line {0x0000_0493, 0x0010_0093, 0x0020_0113, 0x0030_0193} (word3..word0).
  - Required: stall=1 for 5 cycles, mem_req_addr_out=0x10, then rsp_inst_out=0x0030_0193 with stall=0.
- Hit stream: after the above refill, req 0x14, 0x18, 0x1C on consecutive cycles.
  - Required: rsp 0x0020_0113, 0x0010_0093, 0x0000_0493, with no stall and mem_req_valid_out=0.
- Conflict eviction: load line 0x10, then req 0x50 (same index 1, different tag).
  - Required: miss and refill at 0x50. A later req 0x10 misses again.
- Kill in REQ: miss on 0x100 with mem_req_ready_in held 0 for 3 cycles, kill_in pulsed in cycle 2.
  - Required: mem_req_valid_out drops next cycle, state IDLE, stall=0, no line installed. A later req 0x100 misses.
- Kill in WAIT: kill during the refill of 0x200.
  - Required: refill completes and the line is installed. A later req 0x204 hits with no memory request.
- Async reset mid-WAIT: assert rst=0 between request accept and mem_rsp_valid_in.
  - Required: outputs 0 immediately. The stray mem_rsp_valid_in after reset installs nothing. Req 0x0 then misses.
